imem_arbiter: RTL

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// Two-port instruction-memory arbiter: fetch (read-only) and loader (read/write) share one memory port.
// Define IMEM_ARB_RR_EN for round-robin arbitration; default build gives the loader fixed priority.
module imem_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned MEM_BYTES = 16392
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req_valid,
  input  logic [31:0] f_req_addr,
  output logic        f_req_ready,
  output logic        f_rsp_valid,
  output logic [31:0] f_rsp_data,
  output logic        f_rsp_err,
  input  logic        l_req_valid,
  input  logic        l_req_we,
  input  logic [31:0] l_req_addr,
  input  logic [31:0] l_req_wdata,
  output logic        l_req_ready,
  output logic        l_rsp_valid,
  output logic [31:0] l_rsp_data,
  output logic        l_rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [0:0]  S_IDLE   = 1'b0;
  localparam logic [0:0]  S_RESP   = 1'b1;
  localparam logic [31:0] LAST_OFF = 32'(MEM_BYTES - 4);

  logic [0:0]  r_state;
  logic        r_owner_l;
  logic        r_we;
  logic        r_err;

  logic        w_accept;
  logic        w_resp;
  logic        w_grant_l;
  logic        w_fault;
  logic        w_wr;
  logic [31:0] w_addr;
  logic [31:0] w_off;
  logic [31:0] w_rdata;

`ifdef IMEM_ARB_RR_EN
  // r_pref_l set means the loader wins the next tie (fetch was granted last).
  logic r_pref_l;
  assign w_grant_l = l_req_valid & (~f_req_valid | r_pref_l);
`else
  assign w_grant_l = l_req_valid;
`endif

  assign w_accept = (r_state == S_IDLE) & ~rst & (f_req_valid | l_req_valid);
  assign w_resp   = (r_state == S_RESP) & ~rst;

  assign w_addr  = w_grant_l ? l_req_addr : f_req_addr;
  assign w_off   = w_addr - BASE_ADDR;
  assign w_fault = (w_addr[1:0] != 2'b00) | (w_off > LAST_OFF);
  assign w_wr    = w_grant_l & l_req_we;

  assign f_req_ready = w_accept & ~w_grant_l;
  assign l_req_ready = w_accept & w_grant_l;

  // Faulting requests are accepted but never reach the memory.
  assign mem_re    = w_accept & ~w_fault & ~w_wr;
  assign mem_we    = w_accept & ~w_fault & w_wr;
  assign mem_addr  = w_accept ? w_off : 32'd0;
  assign mem_wdata = mem_we ? l_req_wdata : 32'd0;

  assign w_rdata     = (r_we | r_err) ? 32'd0 : mem_rdata;
  assign f_rsp_valid = w_resp & ~r_owner_l;
  assign l_rsp_valid = w_resp & r_owner_l;
  assign f_rsp_data  = f_rsp_valid ? w_rdata : 32'd0;
  assign l_rsp_data  = l_rsp_valid ? w_rdata : 32'd0;
  assign f_rsp_err   = f_rsp_valid & r_err;
  assign l_rsp_err   = l_rsp_valid & r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_owner_l <= 1'b0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
`ifdef IMEM_ARB_RR_EN
      r_pref_l  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state   <= S_RESP;
            r_owner_l <= w_grant_l;
            r_we      <= w_wr;
            r_err     <= w_fault;
`ifdef IMEM_ARB_RR_EN
            r_pref_l  <= ~w_grant_l;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
